icache_refill_controller: RTL and testbench

//  Direct-mapped instruction-cache controller. Sequences two DUAL_PORT_MEMORY instances: one for line data, one for tags.

---
 rtl/icache_refill_controller_pkg.sv | 19 +
 rtl/icache_refill_controller_valid_array.sv | 33 +++
 rtl/icache_refill_controller.sv | 158 +++++++++++++++
 tb/tb_icache_refill_controller.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_controller_pkg.sv
`default_nettype none
// ============================================================================
// icache_refill_controller_pkg : FSM state encoding and fixed widths
// Revision 1.0
// ============================================================================
package icache_refill_controller_pkg;

   localparam int WORD_WIDTH  = 32;
   localparam int STATE_WIDTH = 3;

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_LOOKUP      = 3'd1;
   localparam logic [2:0] S_COMPARE     = 3'd2;
   localparam logic [2:0] S_REFILL_REQ  = 3'd3;
   localparam logic [2:0] S_REFILL_WAIT = 3'd4;
   localparam logic [2:0] S_WRITE       = 3'd5;

endpackage
`default_nettype wire

// File: rtl/icache_refill_controller_valid_array.sv
`default_nettype none
// ============================================================================
// icache_valid_array : per-set valid flops, single-cycle clear of every set
// Revision 1.0
// ============================================================================
module icache_valid_array #(
   parameter int  SETS = 512,
   localparam int IB   = $clog2(SETS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_all,
   input  logic          set_en,
   input  logic [IB-1:0] set_idx,
   input  logic [IB-1:0] lookup_idx,
   output logic          lookup_valid
);

   logic [SETS-1:0] valid;

   // Clear wins over set so a fence can never leave a stale line marked valid.
   always_ff @(posedge clk) begin
      if (rst || clear_all) begin
         valid <= '0;
      end else if (set_en) begin
         valid[set_idx] <= 1'b1;
      end
   end

   assign lookup_valid = valid[lookup_idx];

endmodule
`default_nettype wire

// File: rtl/icache_refill_controller.sv
`default_nettype none
// ============================================================================
// icache_refill_controller : direct-mapped I-cache lookup and line refill FSM
// Revision 1.0
// ============================================================================
module icache_refill_controller
   import icache_refill_controller_pkg::*;
#(
   parameter int  ADDRESS_WIDTH = 32,
   parameter int  LINE_WIDTH    = 512,
   parameter int  SETS          = 512,
   parameter int  READ_LATENCY  = 2,
   localparam int OB            = $clog2(LINE_WIDTH / 8),
   localparam int IB            = $clog2(SETS),
   localparam int TAG_WIDTH     = ADDRESS_WIDTH - IB - OB
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] pc_in,
   input  logic                     pc_valid,
   output logic                     pc_ready,
   input  logic                     fence_i,
   output logic [WORD_WIDTH-1:0]    instruction,
   output logic                     instr_valid,
   output logic [IB-1:0]            mem_read_address,
   output logic                     mem_read_enable,
   output logic [IB-1:0]            mem_write_address,
   output logic                     mem_write_enable,
   output logic [LINE_WIDTH-1:0]    data_mem_in,
   output logic [TAG_WIDTH-1:0]     tag_mem_in,
   input  logic [LINE_WIDTH-1:0]    data_mem_out,
   input  logic [TAG_WIDTH-1:0]     tag_mem_out,
   output logic [ADDRESS_WIDTH-1:0] l2_address,
   output logic                     l2_req_valid,
   input  logic                     l2_req_ready,
   input  logic                     l2_resp_valid,
   input  logic [LINE_WIDTH-1:0]    l2_resp_data
);

   localparam int         WB       = OB - 2;
   localparam logic [7:0] LAT_LAST = 8'(READ_LATENCY - 1);

   logic [STATE_WIDTH-1:0] state;
   logic [TAG_WIDTH-1:0]   tag_q;
   logic [IB-1:0]          idx_q;
   logic [WB-1:0]          word_q;
   logic [LINE_WIDTH-1:0]  line_q;
   logic [7:0]             lat_cnt;
   logic                   fence_pending;
   logic [WORD_WIDTH-1:0]  instr_q;
   logic                   instr_valid_q;
   logic                   idle;
   logic                   fence_now;
   logic                   accept;
   logic                   lookup_valid;
   logic                   hit;
   logic                   unused_pc_bits;

   assign idle           = (state == S_IDLE);
   // A fence that arrived while busy is applied in the first IDLE cycle.
   assign fence_now      = idle && (fence_i || fence_pending);
   assign pc_ready       = !rst && idle && !fence_now;
   assign accept         = pc_ready && pc_valid;
   assign unused_pc_bits = ^pc_in[1:0];

   icache_valid_array #(
      .SETS (SETS)
   ) u_valid_array (
      .clk          (clk),
      .rst          (rst),
      .clear_all    (fence_now),
      .set_en       (state == S_WRITE),
      .set_idx      (idx_q),
      .lookup_idx   (idx_q),
      .lookup_valid (lookup_valid)
   );

   assign hit = lookup_valid && (tag_mem_out == tag_q);

   assign mem_read_enable   = accept;
   assign mem_read_address  = accept ? pc_in[OB +: IB] : '0;
   assign mem_write_enable  = !rst && (state == S_WRITE);
   assign mem_write_address = mem_write_enable ? idx_q  : '0;
   assign data_mem_in       = mem_write_enable ? line_q : '0;
   assign tag_mem_in        = mem_write_enable ? tag_q  : '0;
   assign l2_req_valid      = !rst && (state == S_REFILL_REQ);
   assign l2_address        = l2_req_valid ? {tag_q, idx_q, {OB{1'b0}}} : '0;
   assign instruction       = rst ? '0 : instr_q;
   assign instr_valid       = !rst && instr_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         tag_q         <= '0;
         idx_q         <= '0;
         word_q        <= '0;
         line_q        <= '0;
         lat_cnt       <= '0;
         fence_pending <= 1'b0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         instr_valid_q <= 1'b0;
         if (idle) begin
            fence_pending <= 1'b0;
         end else if (fence_i) begin
            fence_pending <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (accept) begin
                  tag_q   <= pc_in[ADDRESS_WIDTH-1 -: TAG_WIDTH];
                  idx_q   <= pc_in[OB +: IB];
                  word_q  <= pc_in[2 +: WB];
                  lat_cnt <= 8'd1;
                  state   <= (READ_LATENCY > 1) ? S_LOOKUP : S_COMPARE;
               end
            end
            S_LOOKUP: begin
               if (lat_cnt == LAT_LAST) begin
                  state <= S_COMPARE;
               end else begin
                  lat_cnt <= lat_cnt + 8'd1;
               end
            end
            S_COMPARE: begin
               if (hit) begin
                  instr_q       <= data_mem_out[WORD_WIDTH*word_q +: WORD_WIDTH];
                  instr_valid_q <= 1'b1;
                  state         <= S_IDLE;
               end else begin
                  state <= S_REFILL_REQ;
               end
            end
            S_REFILL_REQ: begin
               if (l2_req_ready) begin
                  state <= S_REFILL_WAIT;
               end
            end
            S_REFILL_WAIT: begin
               if (l2_resp_valid) begin
                  line_q <= l2_resp_data;
                  state  <= S_WRITE;
               end
            end
            S_WRITE: begin
               instr_q       <= line_q[WORD_WIDTH*word_q +: WORD_WIDTH];
               instr_valid_q <= 1'b1;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_controller.sv
`default_nettype none
// ============================================================================
// tb_icache_refill_controller : scoreboard bench, READ_LATENCY 2 and 1 instances
// Revision 1.0
// ============================================================================
module tb_icache_refill_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0]  pc_in         [2];
   logic         pc_valid      [2];
   logic         pc_ready      [2];
   logic         fence_i       [2];
   logic [31:0]  instruction   [2];
   logic         instr_valid   [2];
   logic [8:0]   mem_read_address  [2];
   logic         mem_read_enable   [2];
   logic [8:0]   mem_write_address [2];
   logic         mem_write_enable  [2];
   logic [511:0] data_mem_in   [2];
   logic [16:0]  tag_mem_in    [2];
   logic [511:0] data_mem_out  [2];
   logic [16:0]  tag_mem_out   [2];
   logic [31:0]  l2_address    [2];
   logic         l2_req_valid  [2];
   logic         l2_req_ready  [2];
   logic         l2_resp_valid [2];
   logic [511:0] l2_resp_data  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [511:0] dmem [512];
      logic [16:0]  tmem [512];
      logic [511:0] d1, d2;
      logic [16:0]  t1, t2;

      initial begin
         for (int i = 0; i < 512; i++) begin
            dmem[i] = '0;
            tmem[i] = '0;
         end
      end

      always @(posedge clk) begin
         if (mem_read_enable[g]) begin
            d1 <= dmem[mem_read_address[g]];
            t1 <= tmem[mem_read_address[g]];
         end
         d2 <= d1;
         t2 <= t1;
         if (mem_write_enable[g]) begin
            dmem[mem_write_address[g]] <= data_mem_in[g];
            tmem[mem_write_address[g]] <= tag_mem_in[g];
         end
      end

      assign data_mem_out[g] = (g == 0) ? d2 : d1;
      assign tag_mem_out[g]  = (g == 0) ? t2 : t1;

      icache_refill_controller #(
         .READ_LATENCY (2 - g)
      ) u_dut (
         .clk               (clk),
         .rst               (rst),
         .pc_in             (pc_in[g]),
         .pc_valid          (pc_valid[g]),
         .pc_ready          (pc_ready[g]),
         .fence_i           (fence_i[g]),
         .instruction       (instruction[g]),
         .instr_valid       (instr_valid[g]),
         .mem_read_address  (mem_read_address[g]),
         .mem_read_enable   (mem_read_enable[g]),
         .mem_write_address (mem_write_address[g]),
         .mem_write_enable  (mem_write_enable[g]),
         .data_mem_in       (data_mem_in[g]),
         .tag_mem_in        (tag_mem_in[g]),
         .data_mem_out      (data_mem_out[g]),
         .tag_mem_out       (tag_mem_out[g]),
         .l2_address        (l2_address[g]),
         .l2_req_valid      (l2_req_valid[g]),
         .l2_req_ready      (l2_req_ready[g]),
         .l2_resp_valid     (l2_resp_valid[g]),
         .l2_resp_data      (l2_resp_data[g])
      );
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc;
   int iv_before;
   int wcount      [2] = '{0, 0};
   int reqcycles   [2] = '{0, 0};
   int ivcount     [2] = '{0, 0};
   int last_iv_cyc [2] = '{0, 0};
   logic [8:0]  last_waddr [2];
   logic [16:0] last_wtag  [2];
   logic [31:0] exp_q [$];
   logic [511:0] line_a, line_b, line_c;

   always @(posedge clk) cyc++;

   // Scoreboard monitor: every instruction pulse is matched against the queue.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (mem_write_enable[d] === 1'b1) begin
            wcount[d]++;
            last_waddr[d] = mem_write_address[d];
            last_wtag[d]  = tag_mem_in[d];
         end
         if (l2_req_valid[d] === 1'b1) reqcycles[d]++;
         if (instr_valid[d] === 1'b1) begin
            logic [31:0] e;
            total++;
            ivcount[d]++;
            last_iv_cyc[d] = cyc;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL instr_unexpected dut%0d got=%h want=none", d, instruction[d]);
            end else begin
               e = exp_q.pop_front();
               if (instruction[d] !== e) begin
                  bad++;
                  $display("FAIL instr_data dut%0d got=%h want=%h", d, instruction[d], e);
               end
            end
         end
      end
   end

   function automatic logic [511:0] make_line(input logic [31:0] seed);
      logic [511:0] l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = seed + 32'(i) * 32'h0101_0101;
      return l;
   endfunction

   task automatic issue(input int d, input logic [31:0] pc);
      int n = 0;
      iv_before = ivcount[d];
      @(posedge clk); #1;
      pc_in[d] = pc;
      pc_valid[d] = 1'b1;
      @(negedge clk); #1;
      while (pc_ready[d] !== 1'b1 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      total++;
      if (pc_ready[d] !== 1'b1) begin
         bad++;
         $display("FAIL accept_timeout dut%0d pc=%h got_ready=%b want=1", d, pc, pc_ready[d]);
      end
      acc_cyc = cyc;
      @(posedge clk); #1;
      pc_valid[d] = 1'b0;
      pc_in[d] = $urandom;
   endtask

   task automatic serve(input int d, input logic [31:0] exp_addr, input logic [511:0] line,
                        input int stall);
      int n = 0;
      @(negedge clk); #1;
      while (l2_req_valid[d] !== 1'b1 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      total++;
      if (l2_req_valid[d] !== 1'b1 || l2_address[d] !== exp_addr) begin
         bad++;
         $display("FAIL l2_request dut%0d got_valid=%b got_addr=%h want_addr=%h",
                  d, l2_req_valid[d], l2_address[d], exp_addr);
      end
      for (int i = 0; i < stall; i++) begin
         @(negedge clk); #1;
         total++;
         if (l2_req_valid[d] !== 1'b1 || l2_address[d] !== exp_addr) begin
            bad++;
            $display("FAIL l2_stall_hold dut%0d cycle=%0d got_valid=%b got_addr=%h want_addr=%h",
                     d, i, l2_req_valid[d], l2_address[d], exp_addr);
         end
      end
      @(posedge clk); #1;
      l2_req_ready[d] = 1'b1;
      @(posedge clk); #1;
      l2_req_ready[d] = 1'b0;
      @(posedge clk); #1;
      l2_resp_valid[d] = 1'b1;
      l2_resp_data[d]  = line;
      @(posedge clk); #1;
      l2_resp_valid[d] = 1'b0;
      l2_resp_data[d]  = {16{$urandom}};
   endtask

   task automatic wait_instr(input int d);
      int n = 0;
      while (ivcount[d] == iv_before && n < 60) begin
         @(negedge clk); #1;
         n++;
      end
      total++;
      if (ivcount[d] == iv_before) begin
         bad++;
         $display("FAIL instr_timeout dut%0d got=none want=pulse", d);
      end
   endtask

   task automatic test_reset();
      pc_valid[0] = 1'b1;
      pc_in[0] = 32'h0000_1004;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      total++;
      if (pc_ready[0] !== 1'b0 || mem_read_enable[0] !== 1'b0 || instruction[0] !== 32'h0 ||
          instr_valid[0] !== 1'b0 || l2_req_valid[0] !== 1'b0 || mem_write_enable[0] !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs got_ready=%b got_ren=%b got_instr=%h want=all_zero",
                  pc_ready[0], mem_read_enable[0], instruction[0]);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      pc_valid[0] = 1'b0;
      @(negedge clk); #1;
      total++;
      if (pc_ready[0] !== 1'b1 || pc_ready[1] !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready got=%b%b want=11", pc_ready[0], pc_ready[1]);
      end
   endtask

   task automatic test_miss_refill();
      issue(0, 32'h0000_1004);
      exp_q.push_back(32'hDEAD_BEEF);
      serve(0, 32'h0000_1000, line_a, 0);
      wait_instr(0);
      total++;
      if (last_waddr[0] !== 9'h040 || last_wtag[0] !== 17'h0) begin
         bad++;
         $display("FAIL refill_write got_idx=%h got_tag=%h want_idx=040 want_tag=0",
                  last_waddr[0], last_wtag[0]);
      end
   endtask

   task automatic test_hit();
      int r0 = reqcycles[0];
      issue(0, 32'h0000_1004);
      exp_q.push_back(32'hDEAD_BEEF);
      wait_instr(0);
      total++;
      if (last_iv_cyc[0] - acc_cyc != 3) begin
         bad++;
         $display("FAIL hit_latency got=%0d want=3", last_iv_cyc[0] - acc_cyc);
      end
      issue(0, 32'h0000_1008);
      exp_q.push_back(line_a[2*32 +: 32]);
      wait_instr(0);
      total++;
      if (reqcycles[0] != r0) begin
         bad++;
         $display("FAIL hit_no_l2 got_req_cycles=%0d want=0", reqcycles[0] - r0);
      end
   endtask

   task automatic test_conflict();
      issue(0, 32'h0002_1000);
      exp_q.push_back(line_b[31:0]);
      serve(0, 32'h0002_1000, line_b, 0);
      wait_instr(0);
      total++;
      if (last_waddr[0] !== 9'h040 || last_wtag[0] !== 17'h4) begin
         bad++;
         $display("FAIL conflict_write got_idx=%h got_tag=%h want_idx=040 want_tag=4",
                  last_waddr[0], last_wtag[0]);
      end
      issue(0, 32'h0000_1000);
      exp_q.push_back(line_a[31:0]);
      serve(0, 32'h0000_1000, line_a, 0);
      wait_instr(0);
   endtask

   task automatic test_fence();
      @(posedge clk); #1;
      fence_i[0]  = 1'b1;
      pc_valid[0] = 1'b1;
      pc_in[0]    = 32'h0000_1000;
      @(negedge clk); #1;
      total++;
      if (pc_ready[0] !== 1'b0 || mem_read_enable[0] !== 1'b0) begin
         bad++;
         $display("FAIL fence_blocks_accept got_ready=%b got_ren=%b want=0",
                  pc_ready[0], mem_read_enable[0]);
      end
      @(posedge clk); #1;
      fence_i[0]  = 1'b0;
      pc_valid[0] = 1'b0;
      issue(0, 32'h0000_1000);
      exp_q.push_back(line_a[31:0]);
      serve(0, 32'h0000_1000, line_a, 0);
      wait_instr(0);
   endtask

   task automatic test_stall_spurious();
      int w0;
      issue(0, 32'h0000_200C);
      exp_q.push_back(line_c[3*32 +: 32]);
      serve(0, 32'h0000_2000, line_c, 5);
      wait_instr(0);
      w0 = wcount[0];
      @(posedge clk); #1;
      l2_resp_valid[0] = 1'b1;
      l2_resp_data[0]  = line_b;
      repeat (2) @(posedge clk);
      #1;
      l2_resp_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (wcount[0] != w0 || pc_ready[0] !== 1'b1) begin
         bad++;
         $display("FAIL spurious_resp got_writes=%0d got_ready=%b want_writes=0 want_ready=1",
                  wcount[0] - w0, pc_ready[0]);
      end
   endtask

   task automatic test_reset_midrefill();
      int w0;
      issue(0, 32'h0000_3000);
      @(negedge clk); #1;
      @(posedge clk); #1;
      l2_req_ready[0] = 1'b1;
      @(posedge clk); #1;
      l2_req_ready[0] = 1'b0;
      rst = 1'b1;
      @(negedge clk); #1;
      total++;
      if (pc_ready[0] !== 1'b0 || l2_req_valid[0] !== 1'b0 || instruction[0] !== 32'h0 ||
          mem_write_enable[0] !== 1'b0) begin
         bad++;
         $display("FAIL reset_midrefill_outputs got_ready=%b got_req=%b got_instr=%h want=all_zero",
                  pc_ready[0], l2_req_valid[0], instruction[0]);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      total++;
      if (pc_ready[0] !== 1'b1 || l2_req_valid[0] !== 1'b0 || instruction[0] !== 32'h0) begin
         bad++;
         $display("FAIL reset_midrefill_idle got_ready=%b got_req=%b got_instr=%h want=1_0_0",
                  pc_ready[0], l2_req_valid[0], instruction[0]);
      end
      w0 = wcount[0];
      @(posedge clk); #1;
      l2_resp_valid[0] = 1'b1;
      l2_resp_data[0]  = line_c;
      @(posedge clk); #1;
      l2_resp_valid[0] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (wcount[0] != w0) begin
         bad++;
         $display("FAIL late_resp_write got_writes=%0d want=0", wcount[0] - w0);
      end
   endtask

   task automatic test_low_latency();
      issue(1, 32'h0000_1004);
      exp_q.push_back(32'hDEAD_BEEF);
      serve(1, 32'h0000_1000, line_a, 0);
      wait_instr(1);
      issue(1, 32'h0000_1004);
      exp_q.push_back(32'hDEAD_BEEF);
      wait_instr(1);
      total++;
      if (last_iv_cyc[1] - acc_cyc != 2) begin
         bad++;
         $display("FAIL ll_hit_latency got=%0d want=2", last_iv_cyc[1] - acc_cyc);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         pc_in[d] = '0;
         pc_valid[d] = 1'b0;
         fence_i[d] = 1'b0;
         l2_req_ready[d] = 1'b0;
         l2_resp_valid[d] = 1'b0;
         l2_resp_data[d] = '0;
      end
      line_a = make_line(32'h1111_0000);
      line_a[1*32 +: 32] = 32'hDEAD_BEEF;
      line_b = make_line(32'hA5A5_0000);
      line_c = make_line(32'h5A5A_0000);

      test_reset();
      test_miss_refill();
      test_hit();
      test_conflict();
      test_fence();
      test_stall_spurious();
      test_reset_midrefill();
      test_low_latency();

      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got_pending=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
